// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register sequencer: mode codes driven on
// sr_shift and the controller's state type.
package sr_pkg;

   localparam int SR_MODE_W = 2;

   localparam logic [SR_MODE_W-1:0] SR_LOAD = 2'b00;
   localparam logic [SR_MODE_W-1:0] SR_SHL  = 2'b01;
   localparam logic [SR_MODE_W-1:0] SR_SHR  = 2'b10;
   localparam logic [SR_MODE_W-1:0] SR_HOLD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage : sr_pkg

// File: rtl/sr_seq_ctrl.sv
// Sequencer for an external shift register: load, shift by amt, present result.
// Optional op_count output enabled with `define SR_SEQ_CTRL_STATS_EN.
module sr_seq_ctrl
   import sr_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        in_data,
   input  logic                 in_dir,
   input  logic [AW-1:0]        in_amt,
   output logic [SR_MODE_W-1:0] sr_shift,
   output logic [DW-1:0]        sr_d,
   input  logic [DW-1:0]        sr_q,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic                 busy
`ifdef SR_SEQ_CTRL_STATS_EN
   ,output logic [15:0]         op_count
`endif
);

   state_t        r_state;
   state_t        w_next_state;
   logic [DW-1:0] r_data;
   logic          r_dir;
   logic [AW-1:0] r_cnt;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      sr_shift     = SR_HOLD;
      sr_d         = '0;
      in_ready     = 1'b0;
      busy         = 1'b1;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_next_state = ST_LOAD;
         end
         ST_LOAD: begin
            sr_shift     = SR_LOAD;
            sr_d         = r_data;
            w_next_state = (r_cnt != '0) ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            sr_shift = r_dir ? SR_SHR : SR_SHL;
            if (r_cnt == AW'(1)) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            if (r_out_valid && out_ready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // The result is captured one cycle into DONE, so out_data is a flop that
   // cannot move while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_dir       <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_data <= in_data;
                  r_dir  <= in_dir;
                  r_cnt  <= in_amt;
               end
            end
            ST_SHIFT: r_cnt <= r_cnt - AW'(1);
            ST_DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= sr_q;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef SR_SEQ_CTRL_STATS_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_op_count <= '0;
      else if (r_state == ST_DONE && r_out_valid && out_ready)
         r_op_count <= r_op_count + 16'd1;
   end

   assign op_count = r_op_count;
`endif

endmodule : sr_seq_ctrl

// File: tb/tb_sr_seq_ctrl.sv
// Scoreboard bench for sr_seq_ctrl driving a behavioural shift register whose
// q output is fed back on sr_q.
module tb_sr_seq_ctrl;
   import sr_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_dir;
   logic [AW-1:0] in_amt;
   logic [1:0]    sr_shift;
   logic [DW-1:0] sr_d;
   logic [DW-1:0] sr_q = '0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;
`ifdef SR_SEQ_CTRL_STATS_EN
   logic [15:0]   op_count;
`endif

   sr_seq_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_dir(in_dir), .in_amt(in_amt),
      .sr_shift(sr_shift), .sr_d(sr_d), .sr_q(sr_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
`ifdef SR_SEQ_CTRL_STATS_EN
      , .op_count(op_count)
`endif
   );

   always #5 clk = ~clk;

   // The controlled shift register, zero fill on both shift directions.
   always @(posedge clk) begin
      case (sr_shift)
         SR_LOAD: sr_q <= sr_d;
         SR_SHL:  sr_q <= sr_q << 1;
         SR_SHR:  sr_q <= sr_q >> 1;
         default: ;
      endcase
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          dir;
      int            amt;
      int            acc;
   } exp_t;

   exp_t q_exp[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   shl_cnt = 0;
   int   shr_cnt = 0;
   int   hs_since_reset = 0;
   int   ready_mode = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic dir, input int amt);
      logic [DW-1:0] r;
      r = dir ? (d >> amt) : (d << amt);
      return r;
   endfunction

   // Accept watcher: predicts the response at the moment a command is taken.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sr_shift == SR_SHL) shl_cnt++;
         if (sr_shift == SR_SHR) shr_cnt++;
         if (sr_shift != SR_LOAD) check("sr_d_zero", 32'(sr_d), 32'd0);
         if (in_valid && in_ready) begin
            exp_t e;
            e.data = model(in_data, in_dir, int'(in_amt));
            e.dir  = in_dir;
            e.amt  = int'(in_amt);
            e.acc  = cyc + 1;
            q_exp.push_back(e);
            shl_cnt = 0;
            shr_cnt = 0;
         end
      end
   end

   // Output monitor: pops on each out_valid rise and checks while it is held.
   logic prev_valid = 1'b0;
   logic have_cur   = 1'b0;
   exp_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         have_cur   = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (q_exp.size() == 0) begin
               timeout("spurious_out_valid");
            end else begin
               cur      = q_exp.pop_front();
               have_cur = 1'b1;
               check("latency", 32'(cyc - cur.acc), 32'(2 + cur.amt));
               check("shift_cycles", 32'(cur.dir ? shr_cnt : shl_cnt), 32'(cur.amt));
               check("wrong_dir_cycles", 32'(cur.dir ? shl_cnt : shr_cnt), 32'd0);
            end
         end
         if (out_valid && have_cur) begin
            check("out_data", 32'(out_data), 32'(cur.data));
            check("in_ready_in_done", 32'(in_ready), 32'd0);
         end
         if (out_valid && out_ready) begin
            have_cur = 1'b0;
            hs_since_reset++;
         end
         prev_valid = out_valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sr_shift"}, 32'(sr_shift), 32'(SR_HOLD));
      check({tag, "_sr_d"}, 32'(sr_d), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic dir, input logic [AW-1:0] amt);
      bit ok = 0;
      @(posedge clk);
      #1;
      in_data  = d;
      in_dir   = dir;
      in_amt   = amt;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) timeout("accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && !out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) timeout("wait_idle");
   endtask

   task automatic reset_mid_shift();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sr_shift == SR_SHL || sr_shift == SR_SHR) begin
            ok = 1;
            break;
         end
      end
      if (!ok) timeout("reach_shift");
      #1;
      rst_n = 1'b0;
      q_exp.delete();
      hs_since_reset = 0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      check("mid_reset_no_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_dir    = 1'b0;
      in_amt    = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
      in_valid = 1'b0;
      rst_n = 1'b1;

      send(8'h3F, 1'b0, 3'd2);
      wait_idle();
      send(8'h81, 1'b1, 3'd7);
      wait_idle();
      send(8'hA5, 1'b0, 3'd0);
      wait_idle();

      // Consumer stalls in DONE while upstream keeps offering a command.
      ready_mode = 2;
      out_ready  = 1'b0;
      send(8'h5A, 1'b1, 3'd3);
      begin
         bit ok = 0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
               ok = 1;
               break;
            end
         end
         if (!ok) timeout("stall_valid");
      end
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_amt   = 3'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ready_mode = 0;
      wait_idle();

      send(8'hC3, 1'b0, 3'd6);
      reset_mid_shift();
      send(8'h0F, 1'b0, 3'd3);
      wait_idle();

      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         send(DW'($urandom), 1'($urandom), AW'($urandom));
      end
      ready_mode = 0;
      wait_idle();

      check("queue_empty", 32'(q_exp.size()), 32'd0);
`ifdef SR_SEQ_CTRL_STATS_EN
      check("op_count", 32'(op_count), 32'(hs_since_reset & 16'hFFFF));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_sr_seq_ctrl
